triloc_meas_collector: RTL and testbench

// Upstream stage of the TriLoc datapath. Accepts anchor measurements (x, y, range) one at a time on a

---
 rtl/triloc_pkg.sv | 27 ++
 rtl/triloc_meas_collector_if.sv | 34 +++
 rtl/triloc_anchor_slot.sv | 34 +++
 rtl/triloc_meas_collector.sv | 146 ++++++++++++++
 tb/tb_triloc_meas_collector.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/triloc_pkg.sv
// Shared TriLoc types and width helpers used by the measurement collector and the trilateration core.
package triloc_pkg;

  typedef enum logic [1:0] {
    ID_A   = 2'd0,
    ID_B   = 2'd1,
    ID_C   = 2'd2,
    ID_BAD = 2'd3
  } anchor_id_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EMIT    = 2'd2
  } state_e;

  localparam int NUM_ANCHORS = 3;
  localparam int DEF_N       = 8;

  // Ranges carry one extra bit so a full-scale distance stays positive.
  function automatic int range_width(input int n);
    return n + 1;
  endfunction

  localparam int DEF_RW = range_width(DEF_N);

endpackage

// File: rtl/triloc_meas_collector_if.sv
// Measurement input stream plus the registered anchor-set output of the collector.
interface triloc_meas_collector_if #(
  parameter int N     = 8,
  parameter int SEQ_W = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_id;
  logic signed [N-1:0] in_x;
  logic signed [N-1:0] in_y;
  logic signed [N:0]   in_r;

  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] out_xA, out_yA, out_xB, out_yB, out_xC, out_yC;
  logic signed [N:0]   out_rA, out_rB, out_rC;
  logic [SEQ_W-1:0]    out_seq;
  logic                err_pulse;
  logic                tmo_pulse;

  modport slave (
    input  in_valid, in_id, in_x, in_y, in_r, out_ready,
    output in_ready, out_valid,
           out_xA, out_yA, out_xB, out_yB, out_xC, out_yC,
           out_rA, out_rB, out_rC, out_seq, err_pulse, tmo_pulse
  );

  modport master (
    output in_valid, in_id, in_x, in_y, in_r, out_ready,
    input  in_ready, out_valid,
           out_xA, out_yA, out_xB, out_yB, out_xC, out_yC,
           out_rA, out_rB, out_rC, out_seq, err_pulse, tmo_pulse
  );
endinterface

// File: rtl/triloc_anchor_slot.sv
// One buffered anchor measurement (x, y, range) with its valid flag; clear wins over write.
module triloc_anchor_slot #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                wr_en,
  input  logic signed [N-1:0] wr_x,
  input  logic signed [N-1:0] wr_y,
  input  logic signed [N:0]   wr_r,
  output logic signed [N-1:0] x,
  output logic signed [N-1:0] y,
  output logic signed [N:0]   r,
  output logic                vld
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x   <= '0;
      y   <= '0;
      r   <= '0;
      vld <= 1'b0;
    end else if (clr) begin
      vld <= 1'b0;
    end else if (wr_en) begin
      x   <= wr_x;
      y   <= wr_y;
      r   <= wr_r;
      vld <= 1'b1;
    end
  end

endmodule

// File: rtl/triloc_meas_collector.sv
// Gathers one measurement per anchor A/B/C and offers the complete set on a registered handshake;
// stale partial sets are flushed after TIMEOUT idle cycles, illegal samples are dropped and flagged.
module triloc_meas_collector
  import triloc_pkg::*;
#(
  parameter int N       = 8,
  parameter int TIMEOUT = 1024,
  parameter int SEQ_W   = 8
) (
  input logic                     clk,
  input logic                     rst_n,
  triloc_meas_collector_if.slave  bus
);

  localparam int RW = range_width(N);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e           state_reg;
  logic [CW-1:0]    idle_cnt_reg;
  logic [SEQ_W-1:0] seq_reg;
  logic             out_valid_reg;
  logic             err_reg;
  logic             tmo_reg;

  logic signed [N-1:0]  out_x_reg [NUM_ANCHORS];
  logic signed [N-1:0]  out_y_reg [NUM_ANCHORS];
  logic signed [RW-1:0] out_r_reg [NUM_ANCHORS];

  logic signed [N-1:0]  slot_x [NUM_ANCHORS];
  logic signed [N-1:0]  slot_y [NUM_ANCHORS];
  logic signed [RW-1:0] slot_r [NUM_ANCHORS];
  logic signed [N-1:0]  cap_x  [NUM_ANCHORS];
  logic signed [N-1:0]  cap_y  [NUM_ANCHORS];
  logic signed [RW-1:0] cap_r  [NUM_ANCHORS];

  logic [NUM_ANCHORS-1:0] mask;
  logic [NUM_ANCHORS-1:0] wr_sel;
  logic [NUM_ANCHORS-1:0] mask_next;
  logic xfer, bad, good, complete, flush, clr_slots;

  assign xfer      = bus.in_valid & (state_reg != S_EMIT);
  assign bad       = xfer & ((bus.in_id == ID_BAD) | bus.in_r[RW-1]);
  assign good      = xfer & ~bad;
  assign wr_sel    = good ? (3'b001 << bus.in_id) : 3'b000;
  assign mask_next = mask | wr_sel;
  assign complete  = good & (mask_next == 3'b111);
  // Any transfer, good or bad, rescues a partial set from expiring this cycle.
  assign flush     = (state_reg == S_COLLECT) & ~xfer & (idle_cnt_reg == CNT_LAST);
  assign clr_slots = flush | ((state_reg == S_EMIT) & bus.out_ready);

  generate
    for (genvar gi = 0; gi < NUM_ANCHORS; gi++) begin : g_slot
      triloc_anchor_slot #(.N(N)) u_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_slots),
        .wr_en (wr_sel[gi]),
        .wr_x  (bus.in_x),
        .wr_y  (bus.in_y),
        .wr_r  (bus.in_r),
        .x     (slot_x[gi]),
        .y     (slot_y[gi]),
        .r     (slot_r[gi]),
        .vld   (mask[gi])
      );
      // The completing sample is still in flight, so the output capture bypasses its slot.
      assign cap_x[gi] = wr_sel[gi] ? bus.in_x : slot_x[gi];
      assign cap_y[gi] = wr_sel[gi] ? bus.in_y : slot_y[gi];
      assign cap_r[gi] = wr_sel[gi] ? bus.in_r : slot_r[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      idle_cnt_reg  <= '0;
      seq_reg       <= '0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      tmo_reg       <= 1'b0;
      for (int k = 0; k < NUM_ANCHORS; k++) begin
        out_x_reg[k] <= '0;
        out_y_reg[k] <= '0;
        out_r_reg[k] <= '0;
      end
    end else begin
      err_reg <= bad;
      tmo_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          idle_cnt_reg <= '0;
          if (good) state_reg <= S_COLLECT;
        end
        S_COLLECT: begin
          if (complete) begin
            state_reg     <= S_EMIT;
            out_valid_reg <= 1'b1;
            idle_cnt_reg  <= '0;
            for (int k = 0; k < NUM_ANCHORS; k++) begin
              out_x_reg[k] <= cap_x[k];
              out_y_reg[k] <= cap_y[k];
              out_r_reg[k] <= cap_r[k];
            end
          end else if (xfer) begin
            idle_cnt_reg <= '0;
          end else if (flush) begin
            state_reg    <= S_IDLE;
            idle_cnt_reg <= '0;
            tmo_reg      <= 1'b1;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
          end
        end
        S_EMIT: begin
          idle_cnt_reg <= '0;
          if (bus.out_ready) begin
            state_reg     <= S_IDLE;
            out_valid_reg <= 1'b0;
            seq_reg       <= seq_reg + 1'b1;
          end
        end
        default: begin
          state_reg    <= S_IDLE;
          idle_cnt_reg <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_reg != S_EMIT);
  assign bus.out_valid = out_valid_reg;
  assign bus.out_seq   = seq_reg;
  assign bus.err_pulse = err_reg;
  assign bus.tmo_pulse = tmo_reg;
  assign bus.out_xA    = out_x_reg[0];
  assign bus.out_yA    = out_y_reg[0];
  assign bus.out_rA    = out_r_reg[0];
  assign bus.out_xB    = out_x_reg[1];
  assign bus.out_yB    = out_y_reg[1];
  assign bus.out_rB    = out_r_reg[1];
  assign bus.out_xC    = out_x_reg[2];
  assign bus.out_yC    = out_y_reg[2];
  assign bus.out_rC    = out_r_reg[2];

endmodule

// File: tb/tb_triloc_meas_collector.sv
// Scenario bench for triloc_meas_collector: directed scenarios plus a randomized run against a set-level model.
module tb_triloc_meas_collector;

  localparam int N   = 8;
  localparam int TMO = 16;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  int   exp_seq;

  logic [7:0] mx [3];
  logic [7:0] my [3];
  logic [8:0] mr [3];
  logic [2:0] mmask;

  triloc_meas_collector_if #(.N(N), .SEQ_W(8)) bus ();

  triloc_meas_collector #(.N(N), .TIMEOUT(TMO), .SEQ_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [74:0] got_set();
    return {bus.out_xA, bus.out_yA, bus.out_rA, bus.out_xB, bus.out_yB, bus.out_rB,
            bus.out_xC, bus.out_yC, bus.out_rC};
  endfunction

  function automatic logic [74:0] mk(input int xa, ya, ra, xb, yb, rb, xc, yc, rc);
    return {8'(xa), 8'(ya), 9'(ra), 8'(xb), 8'(yb), 9'(rb), 8'(xc), 8'(yc), 9'(rc)};
  endfunction

  // Holds in_valid with the given sample until it is accepted; returns on the following negedge.
  task automatic send(input int id, input int x, input int y, input int r);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_id    = 2'(id);
    bus.in_x     = 8'(x);
    bus.in_y     = 8'(y);
    bus.in_r     = 9'(r);
    while (bus.in_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    compared++;
    if (guard >= 200) begin
      mismatched++;
      $display("FAIL send_ready got=in_ready stuck low required=1 within 200 cycles");
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_id = 2'd0; bus.in_x = '0; bus.in_y = '0; bus.in_r = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_seq !== 8'd0 ||
        bus.err_pulse !== 1'b0 || bus.tmo_pulse !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl got v=%b rdy=%b seq=%0d err=%b tmo=%b required 0 1 0 0 0",
               bus.out_valid, bus.in_ready, bus.out_seq, bus.err_pulse, bus.tmo_pulse);
    end
    compared++;
    if (got_set() !== 75'd0) begin
      mismatched++;
      $display("FAIL reset_data got=%h required=0", got_set());
    end
    exp_seq = 0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    send(0, 3, -4, 5);
    send(1, 10, 0, 7);
    send(2, 0, 10, 9);
    compared++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_valid got v=%b rdy=%b required v=1 rdy=0", bus.out_valid, bus.in_ready);
    end
    compared++;
    if (got_set() !== mk(3, -4, 5, 10, 0, 7, 0, 10, 9)) begin
      mismatched++;
      $display("FAIL basic_set got=%h required=%h", got_set(), mk(3, -4, 5, 10, 0, 7, 0, 10, 9));
    end
    compared++;
    if (bus.out_seq !== 8'(exp_seq)) begin
      mismatched++;
      $display("FAIL basic_seq0 got=%0d required=%0d", bus.out_seq, exp_seq);
    end
    idle();
    @(negedge clk);
    exp_seq++;
    compared++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_seq !== 8'(exp_seq)) begin
      mismatched++;
      $display("FAIL basic_after got v=%b rdy=%b seq=%0d required 0 1 %0d",
               bus.out_valid, bus.in_ready, bus.out_seq, exp_seq);
    end
    $display("test_basic done");
  endtask

  task automatic test_duplicate();
    bus.out_ready = 1'b1;
    send(0, 1, 1, 2);
    send(0, 5, 6, 7);
    compared++;
    if (bus.err_pulse !== 1'b0) begin
      mismatched++;
      $display("FAIL dup_err got=%b required=0", bus.err_pulse);
    end
    send(1, 2, 3, 4);
    send(2, -1, -2, 8);
    compared++;
    if (bus.out_valid !== 1'b1 || got_set() !== mk(5, 6, 7, 2, 3, 4, -1, -2, 8)) begin
      mismatched++;
      $display("FAIL dup_set got v=%b set=%h required v=1 set=%h",
               bus.out_valid, got_set(), mk(5, 6, 7, 2, 3, 4, -1, -2, 8));
    end
    idle();
    @(negedge clk);
    exp_seq++;
    $display("test_duplicate done");
  endtask

  task automatic test_bad_samples();
    int tmo_seen;
    bus.out_ready = 1'b1;
    send(3, 1, 2, 3);
    compared++;
    if (bus.err_pulse !== 1'b1) begin
      mismatched++;
      $display("FAIL bad_id_err got=%b required=1", bus.err_pulse);
    end
    send(1, 4, 4, 9'h1F0);
    compared++;
    if (bus.err_pulse !== 1'b1) begin
      mismatched++;
      $display("FAIL neg_r_err got=%b required=1", bus.err_pulse);
    end
    idle();
    @(negedge clk);
    compared++;
    if (bus.err_pulse !== 1'b0) begin
      mismatched++;
      $display("FAIL err_one_cycle got=%b required=0", bus.err_pulse);
    end
    tmo_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.tmo_pulse === 1'b1) tmo_seen++;
    end
    compared++;
    if (tmo_seen != 0 || bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL bad_idle got tmo=%0d rdy=%b required tmo=0 rdy=1", tmo_seen, bus.in_ready);
    end
    send(0, 1, 2, 3);
    send(2, 7, 8, 9);
    idle();
    @(negedge clk);
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL bad_mask got out_valid=%b required=0", bus.out_valid);
    end
    send(1, 4, 5, 6);
    compared++;
    if (bus.out_valid !== 1'b1 || got_set() !== mk(1, 2, 3, 4, 5, 6, 7, 8, 9)) begin
      mismatched++;
      $display("FAIL bad_set got v=%b set=%h required v=1 set=%h",
               bus.out_valid, got_set(), mk(1, 2, 3, 4, 5, 6, 7, 8, 9));
    end
    idle();
    @(negedge clk);
    exp_seq++;
    $display("test_bad_samples done");
  endtask

  task automatic test_timeout();
    int tmo_cnt;
    bus.out_ready = 1'b1;
    send(0, 9, 9, 9);
    idle();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      compared++;
      if (bus.tmo_pulse !== (k == TMO)) begin
        mismatched++;
        $display("FAIL tmo_timing cycle=%0d got=%b required=%b", k, bus.tmo_pulse, (k == TMO));
      end
    end
    send(1, 1, 1, 1);
    send(2, 2, 2, 2);
    idle();
    tmo_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      compared++;
      if (bus.out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL tmo_no_emit cycle=%0d got=%b required=0", k, bus.out_valid);
      end
      if (bus.tmo_pulse === 1'b1) tmo_cnt++;
    end
    compared++;
    if (tmo_cnt != 1) begin
      mismatched++;
      $display("FAIL tmo_second got=%0d pulses required=1", tmo_cnt);
    end
    $display("test_timeout done");
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    send(0, 11, 12, 13);
    send(1, 14, 15, 16);
    send(2, 17, 18, 19);
    bus.in_id = 2'd0; bus.in_x = 8'd7; bus.in_y = 8'd7; bus.in_r = 9'd7;
    for (int k = 0; k < 20; k++) begin
      compared++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          got_set() !== mk(11, 12, 13, 14, 15, 16, 17, 18, 19)) begin
        mismatched++;
        $display("FAIL bp_hold cycle=%0d got v=%b rdy=%b set=%h required v=1 rdy=0 set=%h", k,
                 bus.out_valid, bus.in_ready, got_set(), mk(11, 12, 13, 14, 15, 16, 17, 18, 19));
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    exp_seq++;
    compared++;
    if (bus.out_valid !== 1'b0 || bus.out_seq !== 8'(exp_seq)) begin
      mismatched++;
      $display("FAIL bp_release got v=%b seq=%0d required v=0 seq=%0d",
               bus.out_valid, bus.out_seq, exp_seq);
    end
    send(0, 7, 7, 7);
    send(1, 1, 1, 1);
    send(2, 2, 2, 2);
    compared++;
    if (bus.out_valid !== 1'b1 || got_set() !== mk(7, 7, 7, 1, 1, 1, 2, 2, 2) ||
        bus.out_seq !== 8'(exp_seq)) begin
      mismatched++;
      $display("FAIL bp_next got v=%b set=%h seq=%0d required v=1 set=%h seq=%0d", bus.out_valid,
               got_set(), bus.out_seq, mk(7, 7, 7, 1, 1, 1, 2, 2, 2), exp_seq);
    end
    idle();
    @(negedge clk);
    exp_seq++;
    $display("test_backpressure done");
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    send(0, 21, 22, 23);
    send(1, 24, 25, 26);
    send(2, 27, 28, 29);
    idle();
    compared++;
    if (bus.out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL arst_pre got out_valid=%b required=1", bus.out_valid);
    end
    #3;
    rst_n = 1'b0;
    #1;
    compared++;
    if (bus.out_valid !== 1'b0 || got_set() !== 75'd0 || bus.out_seq !== 8'd0 ||
        bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL arst_clear got v=%b set=%h seq=%0d rdy=%b required 0 0 0 1",
               bus.out_valid, got_set(), bus.out_seq, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_seq = 0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    send(2, -5, 6, 100);
    send(0, 4, -3, 200);
    send(1, 0, 0, 255);
    compared++;
    if (bus.out_valid !== 1'b1 || got_set() !== mk(4, -3, 200, 0, 0, 255, -5, 6, 100) ||
        bus.out_seq !== 8'd0) begin
      mismatched++;
      $display("FAIL arst_first got v=%b set=%h seq=%0d required v=1 set=%h seq=0", bus.out_valid,
               got_set(), bus.out_seq, mk(4, -3, 200, 0, 0, 255, -5, 6, 100));
    end
    idle();
    @(negedge clk);
    exp_seq++;
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    int id, x, y, r, g, nsets;
    bit is_bad, exp_flush, seen;
    bus.out_ready = 1'b1;
    mmask = 3'b000;
    nsets = 0;
    for (int t = 0; t < 300; t++) begin
      id = $urandom_range(0, 3);
      x  = $urandom_range(0, 255);
      y  = $urandom_range(0, 255);
      r  = ($urandom_range(0, 4) == 0) ? $urandom_range(256, 511) : $urandom_range(0, 255);
      send(id, x, y, r);
      is_bad = (id == 3) || (r >= 256);
      compared++;
      if (bus.err_pulse !== is_bad) begin
        mismatched++;
        $display("FAIL rnd_err t=%0d id=%0d r=%0d got=%b required=%b", t, id, r, bus.err_pulse, is_bad);
      end
      if (!is_bad) begin
        mx[id] = 8'(x); my[id] = 8'(y); mr[id] = 9'(r);
        mmask[id] = 1'b1;
      end
      if (mmask == 3'b111) begin
        compared++;
        if (bus.out_valid !== 1'b1 || bus.out_seq !== 8'(exp_seq) ||
            got_set() !== {mx[0], my[0], mr[0], mx[1], my[1], mr[1], mx[2], my[2], mr[2]}) begin
          mismatched++;
          $display("FAIL rnd_set t=%0d got v=%b seq=%0d set=%h required v=1 seq=%0d set=%h", t,
                   bus.out_valid, bus.out_seq, got_set(), exp_seq,
                   {mx[0], my[0], mr[0], mx[1], my[1], mr[1], mx[2], my[2], mr[2]});
        end
        idle();
        @(negedge clk);
        exp_seq++;
        mmask = 3'b000;
        nsets++;
      end else begin
        compared++;
        if (bus.out_valid !== 1'b0) begin
          mismatched++;
          $display("FAIL rnd_partial t=%0d got out_valid=%b required=0", t, bus.out_valid);
        end
        g = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
        if (g > 0) begin
          idle();
          seen = 1'b0;
          repeat (g) begin
            @(negedge clk);
            if (bus.tmo_pulse === 1'b1) seen = 1'b1;
          end
          exp_flush = (mmask != 3'b000) && (g >= TMO);
          compared++;
          if (seen !== exp_flush) begin
            mismatched++;
            $display("FAIL rnd_tmo t=%0d gap=%0d got=%b required=%b", t, g, seen, exp_flush);
          end
          if (exp_flush) mmask = 3'b000;
        end
      end
    end
    idle();
    @(negedge clk);
    $display("test_random done: %0d sets emitted", nsets);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    exp_seq    = 0;
    test_reset();
    test_basic();
    test_duplicate();
    test_bad_samples();
    test_timeout();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
